// File: rtl/uart_rx_packet_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_packet_checker
// Description : Validates 11-bit UART packets (start/stop framing, optional
//               even parity) and pushes good payload bytes into a small
//               first-word-fall-through FIFO. Bad or dropped packets are
//               counted in saturating counters and flagged with err_pulse.
//               Optional feature macro: PARITY_CHECK_EN (parity check built
//               only when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packet_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              packet_in,
    input  logic                     packet_valid,
    input  logic                     rd_en,
    output logic [7:0]               data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         frame_err_cnt,
    output logic [CNT_W-1:0]         parity_err_cnt,
    output logic [CNT_W-1:0]         overflow_cnt,
    output logic                     err_pulse
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    // Stage-1 capture registers
    logic [10:0]      s1_pkt;
    logic             s1_vld;

    // FIFO storage and pointers
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Classification / FIFO control
    logic             frame_bad;
    logic             parity_bad;
    logic             frame_hit;
    logic             parity_hit;
    logic             good;
    logic             push;
    logic             pop;
    logic             ovf_hit;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count_nxt;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Capture the packet on its strobe; the valid flag only lives one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_pkt <= '0;
        end else begin
            s1_vld <= packet_valid;
            if (packet_valid) begin
                s1_pkt <= packet_in;
            end
        end
    end

    assign frame_bad = s1_pkt[0] | ~s1_pkt[10];

`ifdef PARITY_CHECK_EN
    assign parity_bad = ^s1_pkt[9:1];
`else
    // Parity bit is deliberately ignored in this build
    logic unused_parity_bit;
    assign unused_parity_bit = s1_pkt[9];
    assign parity_bad        = 1'b0;
`endif

    // Framing check takes precedence; parity is only judged on framed packets
    always_comb begin
        frame_hit  = s1_vld & frame_bad;
        parity_hit = s1_vld & ~frame_bad & parity_bad;
        good       = s1_vld & ~frame_bad & ~parity_bad;
        pop        = rd_en & ~empty;
        // A full FIFO can still accept the byte if a slot frees up this cycle
        push       = good & (~full | pop);
        ovf_hit    = good & full & ~pop;
        rd_ptr_nxt = rd_ptr + AW'(pop);
        count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // FIFO array write port (contents need no reset; occupancy guards reads)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s1_pkt[8:1];
        end
    end

    // Pointers, occupancy and the registered head-of-FIFO output
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            // New head is either the byte being written right now (FIFO was
            // empty or about to drain to it) or the stored entry; hold if empty
            if (count_nxt != '0) begin
                if (push && (wr_ptr == rd_ptr_nxt)) begin
                    data_out <= s1_pkt[8:1];
                end else begin
                    data_out <= mem[rd_ptr_nxt];
                end
            end
        end
    end

    // Saturating drop counters and the one-cycle drop indication
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_cnt <= '0;
            overflow_cnt  <= '0;
            err_pulse     <= 1'b0;
        end else begin
            err_pulse <= frame_hit | parity_hit | ovf_hit;
            if (frame_hit && (frame_err_cnt != '1)) begin
                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            end
            if (ovf_hit && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PARITY_CHECK_EN
    // Saturating parity error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_cnt <= '0;
        end else if (parity_hit && (parity_err_cnt != '1)) begin
            parity_err_cnt <= parity_err_cnt + CNT_W'(1);
        end
    end
`else
    assign parity_err_cnt = '0;
`endif

endmodule
`default_nettype wire
